// File: rtl/lt24_lcd_driver_pkg.sv
// ILI9341 opcodes, panel geometry, init-ROM entry format and driver FSM states.
// Shared by the LT24 driver top and its init ROM.
package lt24_pkg;

  localparam logic [7:0] SLPOUT = 8'h11;
  localparam logic [7:0] COLMOD = 8'h3A;
  localparam logic [7:0] MADCTL = 8'h36;
  localparam logic [7:0] CASET  = 8'h2A;
  localparam logic [7:0] PASET  = 8'h2B;
  localparam logic [7:0] DISPON = 8'h29;
  localparam logic [7:0] RAMWR  = 8'h2C;

  localparam int LCD_W     = 320;
  localparam int LCD_H     = 240;
  localparam int PIXEL_NUM = LCD_W * LCD_H;
  localparam int INIT_LEN  = 17;

  typedef struct packed {
    logic       is_data;
    logic       delay_after;
    logic [7:0] value;
  } rom_entry_t;

  typedef enum logic [2:0] {
    S_RESET,
    S_HWRST_LOW,
    S_HWRST_WAIT,
    S_INIT_LOAD,
    S_WR_LOW,
    S_WR_HIGH,
    S_DELAY,
    S_READY
  } state_t;

  function automatic rom_entry_t cmd_e(input logic [7:0] op, input logic dly);
    return '{is_data: 1'b0, delay_after: dly, value: op};
  endfunction

  function automatic rom_entry_t dat_e(input logic [7:0] v);
    return '{is_data: 1'b1, delay_after: 1'b0, value: v};
  endfunction

endpackage

// File: rtl/lt24_lcd_driver_init_rom.sv
// ILI9341 power-up sequence: combinational index -> {is_data, delay_after, byte}.
// Full-screen landscape window, 16 bpp, ends with RAMWR so pixels can stream directly.
module lt24_init_rom
  import lt24_pkg::*;
(
  input  logic [4:0]  index,
  output rom_entry_t  entry
);

  always_comb begin
    entry = '{is_data: 1'b0, delay_after: 1'b0, value: 8'h00};
    case (index)
      5'd0:  entry = cmd_e(SLPOUT, 1'b1);
      5'd1:  entry = cmd_e(COLMOD, 1'b0);
      5'd2:  entry = dat_e(8'h55);
      5'd3:  entry = cmd_e(MADCTL, 1'b0);
      5'd4:  entry = dat_e(8'h28);
      5'd5:  entry = cmd_e(CASET, 1'b0);
      5'd6:  entry = dat_e(8'h00);
      5'd7:  entry = dat_e(8'h00);
      5'd8:  entry = dat_e(8'((LCD_W - 1) >> 8));
      5'd9:  entry = dat_e(8'((LCD_W - 1) & 8'hFF));
      5'd10: entry = cmd_e(PASET, 1'b0);
      5'd11: entry = dat_e(8'h00);
      5'd12: entry = dat_e(8'h00);
      5'd13: entry = dat_e(8'((LCD_H - 1) >> 8));
      5'd14: entry = dat_e(8'((LCD_H - 1) & 8'hFF));
      5'd15: entry = cmd_e(DISPON, 1'b0);
      5'd16: entry = cmd_e(RAMWR, 1'b0);
      default: entry = '{is_data: 1'b0, delay_after: 1'b0, value: 8'h00};
    endcase
  end

endmodule

// File: rtl/lt24_lcd_driver.sv
// LT24 (ILI9341) 8080-bus driver: runs power-up init, then one RGB565 write per accepted print.
// Pixel done pulses 1+WR_LOW+WR_HIGH cycles after print; prints arriving while busy are dropped.
module lt24_lcd_driver
  import lt24_pkg::*;
#(
  parameter int RESET_LOW_CYCLES  = 500000,
  parameter int RESET_WAIT_CYCLES = 6000000,
  parameter int SLEEP_WAIT_CYCLES = 250000,
  parameter int WR_LOW_CYCLES     = 2,
  parameter int WR_HIGH_CYCLES    = 2,
  parameter int PIXEL_COUNT       = PIXEL_NUM
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] pixel_rgb,
  input  logic        print,
  output logic        driver_done,
  output logic        driver_initialized,
  output logic        lcd_cs_n,
  output logic        lcd_wr_n,
  output logic        lcd_rd_n,
  output logic        lcd_rs,
  output logic [15:0] lcd_data,
  output logic        lcd_reset_n,
  output logic        lcd_on
);

  localparam logic [23:0] RST_LOW_LAST  = 24'(RESET_LOW_CYCLES - 1);
  localparam logic [23:0] RST_WAIT_LAST = 24'(RESET_WAIT_CYCLES - 1);
  localparam logic [23:0] SLEEP_LAST    = 24'(SLEEP_WAIT_CYCLES - 1);
  localparam logic [23:0] WR_LOW_LAST   = 24'(WR_LOW_CYCLES - 1);
  localparam logic [23:0] WR_HIGH_LAST  = 24'(WR_HIGH_CYCLES - 1);
  localparam logic [16:0] PIX_LAST      = 17'(PIXEL_COUNT - 1);
  localparam logic [4:0]  INIT_LAST     = 5'(INIT_LEN - 1);

  state_t     state;
  logic [23:0] cnt;
  logic [4:0]  rom_idx;
  logic [16:0] pix_cnt;
  logic        ramwr_pending;
  rom_entry_t  entry;

  lt24_init_rom u_rom (
    .index (rom_idx),
    .entry (entry)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state              <= S_RESET;
      cnt                <= '0;
      rom_idx            <= '0;
      pix_cnt            <= '0;
      ramwr_pending      <= 1'b0;
      lcd_cs_n           <= 1'b1;
      lcd_wr_n           <= 1'b1;
      lcd_rd_n           <= 1'b1;
      lcd_rs             <= 1'b1;
      lcd_data           <= '0;
      lcd_reset_n        <= 1'b0;
      lcd_on             <= 1'b0;
      driver_done        <= 1'b0;
      driver_initialized <= 1'b0;
    end else begin
      driver_done <= 1'b0;
      lcd_rd_n    <= 1'b1;
      case (state)
        S_RESET: begin
          cnt   <= '0;
          state <= S_HWRST_LOW;
        end
        S_HWRST_LOW: begin
          if (cnt == RST_LOW_LAST) begin
            lcd_reset_n <= 1'b1;
            cnt         <= '0;
            state       <= S_HWRST_WAIT;
          end else cnt <= cnt + 24'd1;
        end
        S_HWRST_WAIT: begin
          if (cnt == RST_WAIT_LAST) begin
            cnt   <= '0;
            state <= S_INIT_LOAD;
          end else cnt <= cnt + 24'd1;
        end
        S_INIT_LOAD: begin
          lcd_cs_n <= 1'b0;
          lcd_rs   <= entry.is_data;
          lcd_data <= {8'h00, entry.value};
          lcd_wr_n <= 1'b0;
          cnt      <= '0;
          state    <= S_WR_LOW;
        end
        S_WR_LOW: begin
          if (cnt == WR_LOW_LAST) begin
            lcd_wr_n <= 1'b1;
            cnt      <= '0;
            state    <= S_WR_HIGH;
          end else cnt <= cnt + 24'd1;
        end
        S_WR_HIGH: begin
          if (cnt != WR_HIGH_LAST) begin
            cnt <= cnt + 24'd1;
          end else begin
            cnt <= '0;
            if (!driver_initialized) begin
              if (!entry.is_data && entry.value == DISPON) lcd_on <= 1'b1;
              rom_idx <= rom_idx + 5'd1;
              if (entry.delay_after) state <= S_DELAY;
              else if (rom_idx == INIT_LAST) begin
                driver_initialized <= 1'b1;
                state              <= S_READY;
              end else state <= S_INIT_LOAD;
            end else if (ramwr_pending) begin
              ramwr_pending <= 1'b0;
              driver_done   <= 1'b1;
              state         <= S_READY;
            end else if (pix_cnt == PIX_LAST) begin
              // Frame complete: re-arm RAMWR so the next pixel lands at (0,0).
              pix_cnt       <= '0;
              ramwr_pending <= 1'b1;
              lcd_rs        <= 1'b0;
              lcd_data      <= {8'h00, RAMWR};
              lcd_wr_n      <= 1'b0;
              state         <= S_WR_LOW;
            end else begin
              pix_cnt     <= pix_cnt + 17'd1;
              driver_done <= 1'b1;
              state       <= S_READY;
            end
          end
        end
        S_DELAY: begin
          if (cnt == SLEEP_LAST) begin
            cnt   <= '0;
            state <= S_INIT_LOAD;
          end else cnt <= cnt + 24'd1;
        end
        S_READY: begin
          if (print) begin
            lcd_rs   <= 1'b1;
            lcd_data <= pixel_rgb;
            lcd_wr_n <= 1'b0;
            cnt      <= '0;
            state    <= S_WR_LOW;
          end
        end
        default: state <= S_RESET;
      endcase
    end
  end

endmodule

// File: tb/tb_lt24_lcd_driver.sv
// Scoreboard bench for lt24_lcd_driver: stimulus queues expected bus words and done cycles,
// a negedge monitor pops them on every completed wr_n strobe and every driver_done pulse.
module tb_lt24_lcd_driver;

  localparam int RL  = 4;
  localparam int RW  = 6;
  localparam int SW  = 3;
  localparam int WL  = 2;
  localparam int WH  = 2;
  localparam int PIX = 6;

  // {rs, data} expected for the power-up sequence, hand-listed
  localparam logic [16:0] ROM_EXP [17] = '{
    17'h00011, 17'h0003A, 17'h10055, 17'h00036, 17'h10028,
    17'h0002A, 17'h10000, 17'h10000, 17'h10001, 17'h1003F,
    17'h0002B, 17'h10000, 17'h10000, 17'h10000, 17'h100EF,
    17'h00029, 17'h0002C
  };
  localparam logic [15:0] PIX_TBL [8] = '{
    16'h0001, 16'hFFFF, 16'hAAAA, 16'h5555, 16'h0F0F, 16'hF0F0, 16'h1357, 16'h8000
  };

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        print = 1'b0;
  logic [15:0] pixel_rgb = '0;
  logic        driver_done, driver_initialized;
  logic        lcd_cs_n, lcd_wr_n, lcd_rd_n, lcd_rs, lcd_reset_n, lcd_on;
  logic [15:0] lcd_data;

  lt24_lcd_driver #(
    .RESET_LOW_CYCLES  (RL),
    .RESET_WAIT_CYCLES (RW),
    .SLEEP_WAIT_CYCLES (SW),
    .WR_LOW_CYCLES     (WL),
    .WR_HIGH_CYCLES    (WH),
    .PIXEL_COUNT       (PIX)
  ) dut (
    .clk                (clk),
    .reset              (reset),
    .pixel_rgb          (pixel_rgb),
    .print              (print),
    .driver_done        (driver_done),
    .driver_initialized (driver_initialized),
    .lcd_cs_n           (lcd_cs_n),
    .lcd_wr_n           (lcd_wr_n),
    .lcd_rd_n           (lcd_rd_n),
    .lcd_rs             (lcd_rs),
    .lcd_data           (lcd_data),
    .lcd_reset_n        (lcd_reset_n),
    .lcd_on             (lcd_on)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_errors = 0;
  logic [16:0] exp_wr[$];
  int          exp_done[$];
  int          pix_model = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic fail_now(input string name, input string what);
    n_checks++;
    n_errors++;
    $display("FAIL %s: %s (cycle %0d)", name, what, cyc);
  endtask

  // Bus / done monitor
  bit          prev_wr = 1'b1;
  bit          active = 1'b0;
  bit          unstable = 1'b0;
  int          low_cnt = 0;
  int          hi_cnt = 0;
  int          wr_idx = 0;
  int          fall_cyc [3];
  logic [16:0] lat = '0;

  always @(negedge clk) begin
    if (reset) begin
      prev_wr = 1'b1;
      active  = 1'b0;
      wr_idx  = 0;
    end else begin
      if (driver_done) begin
        if (exp_done.size() == 0) fail_now("done_unexpected", "driver_done high, required no pulse");
        else chk("done_cycle", cyc, exp_done.pop_front());
      end
      if (active && {lcd_rs, lcd_data} != lat) unstable = 1'b1;
      if (prev_wr && !lcd_wr_n) begin
        active   = 1'b1;
        lat      = {lcd_rs, lcd_data};
        unstable = 1'b0;
        low_cnt  = 1;
        hi_cnt   = 0;
        if (wr_idx < 3) fall_cyc[wr_idx] = cyc;
        wr_idx++;
      end else if (active && !lcd_wr_n) begin
        low_cnt++;
      end else if (active && !prev_wr && lcd_wr_n) begin
        chk("wr_low_len", low_cnt, WL);
        if (exp_wr.size() == 0) fail_now("bus_word", "write seen with no expected word queued");
        else chk("bus_word", lat, exp_wr.pop_front());
        if (wr_idx <= 17) chk("init_flags", {lcd_on, driver_initialized}, {wr_idx == 17, 1'b0});
        hi_cnt = 1;
      end else if (active && lcd_wr_n) begin
        hi_cnt++;
      end
      if (active && lcd_wr_n && hi_cnt == WH) begin
        chk("bus_stable", unstable, 0);
        chk("cs_rd", {lcd_cs_n, lcd_rd_n}, 2'b01);
        active = 1'b0;
      end
      prev_wr = lcd_wr_n;
    end
  end

  task automatic do_reset_init();
    int low;
    bit seen;
    reset = 1'b1;
    print = 1'b0;
    exp_wr.delete();
    exp_done.delete();
    pix_model = 0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 17; i++) exp_wr.push_back(ROM_EXP[i]);
    low = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (lcd_reset_n) break;
      low++;
    end
    chk("reset_n_low_cycles", low, RL);
    seen = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      print = 1'b0;
      if (driver_initialized) begin
        seen = 1'b1;
        break;
      end
      // stray prints during init must be dropped
      if (i % 6 == 2) begin
        print     = 1'b1;
        pixel_rgb = 16'hDEAD;
      end
    end
    if (!seen) fail_now("init_timeout", "driver_initialized never rose within 400 cycles");
    chk("init_write_count", wr_idx, 17);
    chk("slpout_gap", fall_cyc[1] - fall_cyc[0], WL + WH + 1 + SW);
    chk("write_spacing", fall_cyc[2] - fall_cyc[1], WL + WH + 1);
    chk("lcd_on_after_init", lcd_on, 1);
    chk("init_queue_empty", exp_wr.size(), 0);
  endtask

  // mode 0: one-cycle print, 1: print held, 2: extra print one cycle after acceptance
  task automatic send(input logic [15:0] p, input int mode);
    int wait_n;
    print     = 1'b1;
    pixel_rgb = p;
    exp_wr.push_back({1'b1, p});
    if (pix_model == PIX - 1) begin
      exp_wr.push_back({1'b0, 16'h002C});
      wait_n    = 2 * (WL + WH) + 1;
      pix_model = 0;
    end else begin
      wait_n = WL + WH + 1;
      pix_model++;
    end
    // print seen at edge cyc+1; done visible after wait_n-1 further edges
    exp_done.push_back(cyc + wait_n);
    @(negedge clk);
    if (mode == 0) print = 1'b0;
    if (mode == 2) begin
      pixel_rgb = 16'h001F;
      @(negedge clk);
      print = 1'b0;
      repeat (wait_n - 2) @(negedge clk);
    end else begin
      repeat (wait_n - 1) @(negedge clk);
    end
  endtask

  initial begin
    do_reset_init();
    send(16'hF800, 0);
    send(16'h07E0, 2);
    for (int i = 0; i < 8; i++) send(PIX_TBL[i], 1);
    print = 1'b0;
    repeat (2) @(negedge clk);

    // reset while wr_n is low
    print     = 1'b1;
    pixel_rgb = 16'h1234;
    @(negedge clk);
    print = 1'b0;
    chk("midwrite_wr_low", lcd_wr_n, 0);
    reset = 1'b1;
    @(negedge clk);
    chk("reset_outputs",
        {lcd_cs_n, lcd_wr_n, lcd_rd_n, lcd_rs, lcd_data, lcd_reset_n, lcd_on, driver_done, driver_initialized},
        24'hF00000);
    do_reset_init();
    for (int i = 0; i < PIX; i++) send(PIX_TBL[7 - i], 1);
    print = 1'b0;

    repeat (20) @(negedge clk);
    chk("done_queue_empty", exp_done.size(), 0);
    chk("write_queue_empty", exp_wr.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
